// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one slave memory port: data has priority over
// instruction fetch, bounded by a starvation limit, with a per-transaction timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_instr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_valid,
    input  logic        d_instr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_valid,
    output logic        m_instr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        timeout,
    output logic        busy
);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Index 0 is the instruction requester, index 1 the data requester.
    req_t        req_in  [2];
    req_t        req_q   [2];
    req_t        req_d   [2];
    req_t        sel_req [2];
    logic [31:0] rdata_o [2];
    logic [1:0]  valid_in;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  done, cap, eff;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] tmo_q, tmo_d;
    logic        m_valid_q, m_valid_d;
    req_t        m_req_q, m_req_d;

    logic        hit_tmo;
    logic        done_any;
    logic        grant;
    logic        win_d;

    assign req_in[0] = '{instr: i_instr, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb};
    assign req_in[1] = '{instr: d_instr, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
    assign valid_in  = {d_valid, i_valid};

    assign hit_tmo  = (state_q == BUSY) && !m_ready && (tmo_q == TMO_MAX);
    assign done_any = (state_q == BUSY) && (m_ready || hit_tmo);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            localparam logic OWN = 1'(gi);
            assign done[gi] = done_any && (owner_q == OWN);
            // A new request is accepted when the slot is free or frees this cycle.
            assign cap[gi]     = valid_in[gi] && (!pend_q[gi] || done[gi]);
            assign eff[gi]     = (pend_q[gi] && !done[gi]) || cap[gi];
            assign sel_req[gi] = cap[gi] ? req_in[gi] : req_q[gi];
            assign pend_d[gi]  = cap[gi] | (pend_q[gi] & ~done[gi]);
            assign req_d[gi]   = cap[gi] ? req_in[gi] : req_q[gi];
            assign rdata_o[gi] = (done[gi] && !hit_tmo) ? m_rdata : 32'd0;
        end
    endgenerate

    assign grant = ((state_q == IDLE) || done_any) && (eff[0] || eff[1]);
    assign win_d = eff[1] && (!eff[0] || (starve_q != STARVE_MAX));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        m_valid_d = 1'b0;
        m_req_d   = m_req_q;

        if (state_q == BUSY) begin
            tmo_d = tmo_q + 16'd1;
        end
        if (done_any) begin
            state_d = IDLE;
            tmo_d   = 16'd0;
        end
        if (!eff[0]) begin
            starve_d = 4'd0;
        end
        // Completion and the next issue share a cycle so back-to-back requests lose no cycle.
        if (grant) begin
            state_d   = BUSY;
            owner_d   = win_d;
            m_valid_d = 1'b1;
            m_req_d   = win_d ? sel_req[1] : sel_req[0];
            tmo_d     = 16'd0;
            if (!win_d) begin
                starve_d = 4'd0;
            end else if (eff[0] && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            starve_q  <= 4'd0;
            tmo_q     <= 16'd0;
            m_valid_q <= 1'b0;
            m_req_q   <= '0;
            pend_q    <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                req_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            m_valid_q <= m_valid_d;
            m_req_q   <= m_req_d;
            pend_q    <= pend_d;
            for (int k = 0; k < 2; k++) begin
                req_q[k] <= req_d[k];
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_instr = m_req_q.instr;
    assign m_addr  = m_req_q.addr;
    assign m_wdata = m_req_q.wdata;
    assign m_wstrb = m_req_q.wstrb;
    assign busy    = (state_q == BUSY);
    assign timeout = hit_tmo;
    assign i_ready = done[0];
    assign d_ready = done[1];
    assign i_rdata = rdata_o[0];
    assign d_rdata = rdata_o[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected slave requests,
// responses and state snapshots; a monitor pops and compares them at negedge.
module tb_mem_arbiter;
    localparam int          SL  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] KEY = 32'hDEADBFEF;

    logic        clk, rst;
    logic        i_valid, i_instr, d_valid, d_instr;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic        m_valid, m_instr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_ready, timeout, busy;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_valid(d_valid), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
        .timeout(timeout), .busy(busy)
    );

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } mexp_t;

    typedef struct packed {
        logic        port;   // 1 = data requester
        logic [31:0] data;
        logic        tmo;
        int          cyc;
    } rexp_t;

    typedef struct packed {
        int          cyc;
        logic        busy;
        logic        mvalid;
        logic        tmo;
        logic [31:0] addr;
    } sexp_t;

    mexp_t mq[$];
    rexp_t rq[$];
    sexp_t sq[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    logic slave_on = 1'b1;
    int   slave_lat = 1;
    logic stray = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // Slave model: answers each accepted request after slave_lat cycles with addr ^ KEY.
    initial begin
        int          resp_cnt;
        logic [31:0] raddr;
        resp_cnt = 0;
        raddr    = 32'd0;
        m_ready  = 1'b0;
        m_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (m_valid && slave_on) begin
                resp_cnt = slave_lat;
                raddr    = m_addr;
            end
            @(posedge clk);
            #2;
            m_ready = 1'b0;
            m_rdata = 32'd0;
            if (stray) begin
                m_ready = 1'b1;
                m_rdata = 32'hBAD0BAD0;
            end else if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    m_ready = 1'b1;
                    m_rdata = raddr ^ KEY;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s: event seen with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard checker.
    initial begin
        int    stall_seen;
        mexp_t me;
        rexp_t re;
        sexp_t se;
        stall_seen = 0;
        forever begin
            @(negedge clk);
            if (stall_cnt != stall_seen) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL drain_timeout: expectations still queued, expected all consumed (cycle %0d)", cyc);
                stall_seen = stall_cnt;
            end
            if (m_valid) begin
                if (mq.size() == 0) begin
                    flag("m_valid_unexpected");
                end else begin
                    me = mq.pop_front();
                    $display("slave req  cyc=%0d instr=%0b addr=%h wdata=%h wstrb=%h",
                             cyc, m_instr, m_addr, m_wdata, m_wstrb);
                    check("m_cycle", cyc, me.cyc);
                    check("m_instr", {31'd0, m_instr}, {31'd0, me.instr});
                    check("m_addr", m_addr, me.addr);
                    check("m_wdata", m_wdata, me.wdata);
                    check("m_wstrb", {28'd0, m_wstrb}, {28'd0, me.wstrb});
                end
            end
            if (i_ready && d_ready) begin
                flag("both_ready");
            end
            if (i_ready || d_ready) begin
                if (rq.size() == 0) begin
                    flag("ready_unexpected");
                end else begin
                    re = rq.pop_front();
                    $display("response   cyc=%0d port=%s data=%h timeout=%0b",
                             cyc, d_ready ? "d" : "i", d_ready ? d_rdata : i_rdata, timeout);
                    check("resp_port_d", {31'd0, d_ready}, {31'd0, re.port});
                    check("resp_data", d_ready ? d_rdata : i_rdata, re.data);
                    check("resp_timeout", {31'd0, timeout}, {31'd0, re.tmo});
                    check("resp_cycle", cyc, re.cyc);
                end
            end else begin
                check("timeout_idle", {31'd0, timeout}, 32'd0);
            end
            if (!i_ready) check("i_rdata_idle", i_rdata, 32'd0);
            if (!d_ready) check("d_rdata_idle", d_rdata, 32'd0);
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                se = sq.pop_front();
                check("state_cycle", cyc, se.cyc);
                check("busy", {31'd0, busy}, {31'd0, se.busy});
                check("m_valid", {31'd0, m_valid}, {31'd0, se.mvalid});
                check("timeout", {31'd0, timeout}, {31'd0, se.tmo});
                check("m_addr_hold", m_addr, se.addr);
                $display("state      cyc=%0d busy=%0b m_valid=%0b m_addr=%h", cyc, busy, m_valid, m_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int c);
        mexp_t e;
        e = '{instr: instr, addr: addr, wdata: wdata, wstrb: wstrb, cyc: c};
        mq.push_back(e);
    endtask

    task automatic push_r(input logic port, input logic [31:0] data, input logic tmo, input int c);
        rexp_t e;
        e = '{port: port, data: data, tmo: tmo, cyc: c};
        rq.push_back(e);
    endtask

    task automatic push_s(input int c, input logic b, input logic mv, input logic t, input logic [31:0] a);
        sexp_t e;
        e = '{cyc: c, busy: b, mvalid: mv, tmo: t, addr: a};
        sq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || rq.size() != 0) && n < budget) begin
            tick();
            n = n + 1;
        end
        if (mq.size() != 0 || rq.size() != 0) begin
            stall_cnt = stall_cnt + 1;
            mq.delete();
            rq.delete();
        end
        tick();
        tick();
    endtask

    task automatic set_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        d_valid = 1'b1;
        d_instr = 1'b0;
        d_addr  = addr;
        d_wdata = wdata;
        d_wstrb = wstrb;
    endtask

    task automatic set_i(input logic [31:0] addr);
        i_valid = 1'b1;
        i_instr = 1'b1;
        i_addr  = addr;
        i_wdata = 32'd0;
        i_wstrb = 4'd0;
    endtask

    initial begin
        int t;
        rst = 1'b0;
        i_valid = 1'b0; i_instr = 1'b0; i_addr = 32'd0; i_wdata = 32'd0; i_wstrb = 4'd0;
        d_valid = 1'b0; d_instr = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;

        // Reset state
        tick();
        push_s(cyc, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single read
        t = cyc;
        set_d(32'h100, 32'd0, 4'h0);
        push_m(1'b0, 32'h100, 32'd0, 4'h0, t + 1);
        push_r(1'b1, 32'hDEADBEEF, 1'b0, t + 2);
        push_s(t + 1, 1'b1, 1'b1, 1'b0, 32'h100);
        tick();
        d_valid = 1'b0;
        drain(20);

        // Collision: data first, instruction not lost
        t = cyc;
        set_i(32'h0);
        set_d(32'h200, 32'd0, 4'h0);
        push_m(1'b0, 32'h200, 32'd0, 4'h0, t + 1);
        push_r(1'b1, 32'h200 ^ KEY, 1'b0, t + 2);
        push_m(1'b1, 32'h0, 32'd0, 4'h0, t + 3);
        push_r(1'b0, 32'h0 ^ KEY, 1'b0, t + 4);
        tick();
        i_valid = 1'b0;
        d_valid = 1'b0;
        drain(20);

        // Starvation: four data grants, then instruction, then data again
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push_m(1'b0, 32'h300 + 32'(4 * k), 32'd0, 4'h0, t + 2 * k + 1);
            push_r(1'b1, (32'h300 + 32'(4 * k)) ^ KEY, 1'b0, t + 2 * k + 2);
        end
        push_m(1'b1, 32'h40, 32'd0, 4'h0, t + 9);
        push_r(1'b0, 32'h40 ^ KEY, 1'b0, t + 10);
        push_m(1'b0, 32'h310, 32'd0, 4'h0, t + 11);
        push_r(1'b1, 32'h310 ^ KEY, 1'b0, t + 12);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_i(32'h40);
            set_d(32'h300 + 32'(4 * k), 32'd0, 4'h0);
            tick();
            i_valid = 1'b0;
            d_valid = 1'b0;
            tick();
        end
        drain(20);

        // Timeout on a write, then a stray late response
        slave_on = 1'b0;
        t = cyc;
        set_d(32'h400, 32'h12345678, 4'hF);
        push_m(1'b0, 32'h400, 32'h12345678, 4'hF, t + 1);
        push_r(1'b1, 32'd0, 1'b1, t + 9);
        push_s(t + 8, 1'b1, 1'b0, 1'b0, 32'h400);
        push_s(t + 10, 1'b0, 1'b0, 1'b0, 32'h400);
        tick();
        d_valid = 1'b0;
        drain(20);
        stray = 1'b1;
        push_s(cyc, 1'b0, 1'b0, 1'b0, 32'h400);
        tick();
        stray = 1'b0;
        tick();

        // Reset while busy with an instruction request pending
        t = cyc;
        set_i(32'h80);
        set_d(32'h600, 32'd0, 4'h0);
        push_m(1'b0, 32'h600, 32'd0, 4'h0, t + 1);
        tick();
        i_valid = 1'b0;
        d_valid = 1'b0;
        tick();
        rst = 1'b0;
        push_s(t + 2, 1'b1, 1'b0, 1'b0, 32'h600);
        tick();
        rst = 1'b1;
        push_s(t + 3, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        stray = 1'b1;
        push_s(t + 5, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        stray = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        push_s(cyc, 1'b0, 1'b0, 1'b0, 32'd0);
        slave_on = 1'b1;
        tick();

        // Re-request in the same cycle as ready
        t = cyc;
        set_d(32'h500, 32'd0, 4'h0);
        push_m(1'b0, 32'h500, 32'd0, 4'h0, t + 1);
        push_r(1'b1, 32'h500 ^ KEY, 1'b0, t + 2);
        push_m(1'b0, 32'h504, 32'd0, 4'h0, t + 3);
        push_r(1'b1, 32'h504 ^ KEY, 1'b0, t + 4);
        tick();
        d_valid = 1'b0;
        tick();
        set_d(32'h504, 32'd0, 4'h0);
        tick();
        d_valid = 1'b0;
        drain(20);

        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
